// File: rtl/pcfu_pkg.sv
// Shared definitions for the PC fetch unit: FSM state encoding and datapath widths.
// Optional performance counters in pc_fetch_unit are enabled by PCFU_PERF_CNT_EN.
package pcfu_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;

    localparam logic [INSTR_W-1:0] RESET_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2
    } pcfu_state_e;

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC candidates: PC+4 and the branch target PC+4 + sext(offset)*4.
// Shared with the branch-verify bench, so it carries no state.
module pc_next_calc
    import pcfu_pkg::*;
#(
    parameter int OFFSET_W = 8
) (
    input  logic [ADDR_W-1:0]   pc,
    input  logic [OFFSET_W-1:0] offset,
    output logic [ADDR_W-1:0]   pc_plus4,
    output logic [ADDR_W-1:0]   target
);

    logic [ADDR_W-1:0] byte_offset;

    // Word offset becomes a byte offset: two zero LSBs, offset bits, then sign fill.
    genvar gi;
    generate
        for (gi = 0; gi < ADDR_W; gi++) begin : g_byte_offset
            if (gi < 2) begin : g_zero
                assign byte_offset[gi] = 1'b0;
            end else if (gi < OFFSET_W + 2) begin : g_field
                assign byte_offset[gi] = offset[gi-2];
            end else begin : g_sign
                assign byte_offset[gi] = offset[OFFSET_W-1];
            end
        end
    endgenerate

    assign pc_plus4 = pc + 32'd4;
    assign target   = pc_plus4 + byte_offset;

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction-fetch FSM (IDLE -> FETCH -> EXEC -> FETCH ...).
// Define PCFU_PERF_CNT_EN to add the RETIRED_CNT / STALL_CNT performance counters.
module pc_fetch_unit
    import pcfu_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000,
    parameter int                OFFSET_W = 8
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                BRANCH_SEL,
    input  logic [OFFSET_W-1:0] OFFSET,
    input  logic                CORE_STALL,
    input  logic                IMEM_BUSYWAIT,
    input  logic [INSTR_W-1:0]  IMEM_INSTR,
    output logic                IMEM_READ,
    output logic [ADDR_W-1:0]   IMEM_ADDR,
    output logic [INSTR_W-1:0]  INSTRUCTION,
    output logic                INSTR_VALID,
    output logic [ADDR_W-1:0]   PC,
    output logic [ADDR_W-1:0]   PC_PLUS4
`ifdef PCFU_PERF_CNT_EN
    ,
    output logic [31:0]         RETIRED_CNT,
    output logic [31:0]         STALL_CNT
`endif
);

    pcfu_state_e        state_reg;
    logic [ADDR_W-1:0]  pc_reg;
    logic [INSTR_W-1:0] instr_reg;
    logic               valid_reg;
    logic               read_reg;
    logic [ADDR_W-1:0]  pc_plus4;
    logic [ADDR_W-1:0]  pc_target;

    pc_next_calc #(
        .OFFSET_W (OFFSET_W)
    ) u_next (
        .pc       (pc_reg),
        .offset   (OFFSET),
        .pc_plus4 (pc_plus4),
        .target   (pc_target)
    );

    // Outputs are registered alongside the state so IMEM_READ never glitches.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg <= S_IDLE;
            pc_reg    <= RESET_PC;
            instr_reg <= RESET_INSTR;
            valid_reg <= 1'b0;
            read_reg  <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    state_reg <= S_FETCH;
                    read_reg  <= 1'b1;
                end
                S_FETCH: begin
                    if (!IMEM_BUSYWAIT) begin
                        instr_reg <= IMEM_INSTR;
                        valid_reg <= 1'b1;
                        read_reg  <= 1'b0;
                        state_reg <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (!CORE_STALL) begin
                        pc_reg    <= BRANCH_SEL ? pc_target : pc_plus4;
                        valid_reg <= 1'b0;
                        read_reg  <= 1'b1;
                        state_reg <= S_FETCH;
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                    valid_reg <= 1'b0;
                    read_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign IMEM_READ   = read_reg;
    assign IMEM_ADDR   = pc_reg;
    assign INSTRUCTION = instr_reg;
    assign INSTR_VALID = valid_reg;
    assign PC          = pc_reg;
    assign PC_PLUS4    = pc_plus4;

`ifdef PCFU_PERF_CNT_EN
    logic [31:0] retired_cnt_reg;
    logic [31:0] stall_cnt_reg;

    // A stall cycle is any edge where the unit wanted to advance but could not.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            retired_cnt_reg <= 32'd0;
            stall_cnt_reg   <= 32'd0;
        end else begin
            if (state_reg == S_EXEC && !CORE_STALL) begin
                retired_cnt_reg <= retired_cnt_reg + 32'd1;
            end
            if ((state_reg == S_FETCH && IMEM_BUSYWAIT) ||
                (state_reg == S_EXEC && CORE_STALL)) begin
                stall_cnt_reg <= stall_cnt_reg + 32'd1;
            end
        end
    end

    assign RETIRED_CNT = retired_cnt_reg;
    assign STALL_CNT   = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios followed by randomized transactions.
// Two instances share stimulus: one resets to 0, the other to 0xFFFF_FFFC to exercise wrap.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        branch_sel;
    logic [7:0]  offset;
    logic        core_stall;
    logic        busywait;
    logic [31:0] imem_instr;

    logic        imem_read_a, imem_read_b;
    logic [31:0] imem_addr_a, imem_addr_b;
    logic [31:0] instruction_a, instruction_b;
    logic        instr_valid_a, instr_valid_b;
    logic [31:0] pc_a, pc_b;
    logic [31:0] pc_plus4_a, pc_plus4_b;
`ifdef PCFU_PERF_CNT_EN
    logic [31:0] retired_a, retired_b;
    logic [31:0] stalls_a, stalls_b;
`endif

    localparam logic [31:0] RESET_PC_B = 32'hFFFF_FFFC;

    always #5 clk = ~clk;

    pc_fetch_unit #(.RESET_PC(32'h0000_0000), .OFFSET_W(8)) dut_a (
        .CLK           (clk),
        .RESET         (rst),
        .BRANCH_SEL    (branch_sel),
        .OFFSET        (offset),
        .CORE_STALL    (core_stall),
        .IMEM_BUSYWAIT (busywait),
        .IMEM_INSTR    (imem_instr),
        .IMEM_READ     (imem_read_a),
        .IMEM_ADDR     (imem_addr_a),
        .INSTRUCTION   (instruction_a),
        .INSTR_VALID   (instr_valid_a),
        .PC            (pc_a),
        .PC_PLUS4      (pc_plus4_a)
`ifdef PCFU_PERF_CNT_EN
        ,
        .RETIRED_CNT   (retired_a),
        .STALL_CNT     (stalls_a)
`endif
    );

    pc_fetch_unit #(.RESET_PC(RESET_PC_B), .OFFSET_W(8)) dut_b (
        .CLK           (clk),
        .RESET         (rst),
        .BRANCH_SEL    (branch_sel),
        .OFFSET        (offset),
        .CORE_STALL    (core_stall),
        .IMEM_BUSYWAIT (busywait),
        .IMEM_INSTR    (imem_instr),
        .IMEM_READ     (imem_read_b),
        .IMEM_ADDR     (imem_addr_b),
        .INSTRUCTION   (instruction_b),
        .INSTR_VALID   (instr_valid_b),
        .PC            (pc_b),
        .PC_PLUS4      (pc_plus4_b)
`ifdef PCFU_PERF_CNT_EN
        ,
        .RETIRED_CNT   (retired_b),
        .STALL_CNT     (stalls_b)
`endif
    );

    int passes = 0;
    int fails  = 0;
    int checks = 0;

    // Reference model: architectural PC of each instance plus expected counter values.
    logic [31:0] exp_pc_a;
    logic [31:0] exp_pc_b;
    logic [31:0] exp_retired;
    logic [31:0] exp_stalls;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    function automatic logic [31:0] next_pc(input logic [31:0] pc, input logic br,
                                            input logic [7:0] off);
        int signed words;
        words = $signed(off);
        if (br) return pc + 32'd4 + 32'(words * 4);
        return pc + 32'd4;
    endfunction

    task automatic check_counters();
`ifdef PCFU_PERF_CNT_EN
        check("retired_cnt_a", retired_a, exp_retired);
        check("stall_cnt_a", stalls_a, exp_stalls);
        check("stall_cnt_b", stalls_b, exp_stalls);
`endif
    endtask

    // One fetch/execute transaction; entered and left at a negedge with the unit in FETCH.
    task automatic do_instr(input int miss, input int stall, input logic br,
                            input logic [7:0] off, input logic [31:0] word);
        check("fetch_read_a", {31'd0, imem_read_a}, 32'd1);
        check("fetch_addr_a", imem_addr_a, exp_pc_a);
        check("fetch_addr_b", imem_addr_b, exp_pc_b);
        check("pc_plus4_a", pc_plus4_a, exp_pc_a + 32'd4);
        for (int k = 0; k < miss; k++) begin
            busywait   = 1'b1;
            imem_instr = $urandom;
            branch_sel = 1'($urandom);
            offset     = 8'($urandom);
            core_stall = 1'($urandom);
            step();
            exp_stalls++;
            check("miss_read", {31'd0, imem_read_a}, 32'd1);
            check("miss_addr", imem_addr_a, exp_pc_a);
            check("miss_valid", {31'd0, instr_valid_a}, 32'd0);
        end
        busywait   = 1'b0;
        imem_instr = word;
        core_stall = 1'($urandom);
        step();
        check("exec_valid", {31'd0, instr_valid_a}, 32'd1);
        check("exec_instr_a", instruction_a, word);
        check("exec_instr_b", instruction_b, word);
        check("exec_read", {31'd0, imem_read_a}, 32'd0);
        busywait   = 1'($urandom);
        imem_instr = $urandom;
        for (int k = 0; k < stall; k++) begin
            core_stall = 1'b1;
            branch_sel = 1'($urandom);
            offset     = 8'($urandom);
            step();
            exp_stalls++;
            check("stall_valid", {31'd0, instr_valid_a}, 32'd1);
            check("stall_pc", pc_a, exp_pc_a);
            check("stall_instr", instruction_a, word);
        end
        core_stall = 1'b0;
        branch_sel = br;
        offset     = off;
        step();
        exp_pc_a = next_pc(exp_pc_a, br, off);
        exp_pc_b = next_pc(exp_pc_b, br, off);
        exp_retired++;
        check("retire_valid", {31'd0, instr_valid_a}, 32'd0);
        check("retire_pc_a", pc_a, exp_pc_a);
        check("retire_pc_b", pc_b, exp_pc_b);
        check_counters();
        $display("instr word=%h miss=%0d stall=%0d br=%0d off=%h -> next pc_a=%h pc_b=%h",
                 word, miss, stall, br, off, exp_pc_a, exp_pc_b);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst        = 1'b1;
        branch_sel = 1'b0;
        offset     = 8'h00;
        core_stall = 1'b0;
        busywait   = 1'b0;
        imem_instr = 32'h0;
        exp_pc_a    = 32'h0;
        exp_pc_b    = RESET_PC_B;
        exp_retired = 32'd0;
        exp_stalls  = 32'd0;
        step();
        step();
        check("rst_read", {31'd0, imem_read_a}, 32'd0);
        check("rst_valid", {31'd0, instr_valid_a}, 32'd0);
        check("rst_instr", instruction_a, 32'h0);
        check("rst_pc_a", pc_a, 32'h0);
        check("rst_pc_b", pc_b, RESET_PC_B);
        check_counters();

        // Release reset: one IDLE cycle, then the first request appears.
        rst = 1'b0;
        step();

        do_instr(0, 0, 1'b0, 8'h00, 32'hA000_0001);
        do_instr(0, 0, 1'b0, 8'h00, 32'hA000_0002);
        do_instr(5, 0, 1'b0, 8'h00, 32'hA000_0003);
        do_instr(0, 0, 1'b0, 8'h00, 32'hA000_0004);
        do_instr(0, 0, 1'b1, 8'hFC, 32'hA000_0005);
        check("branch_back_addr", imem_addr_a, 32'h0000_0004);
        do_instr(0, 0, 1'b0, 8'h00, 32'hA000_0006);
        do_instr(0, 0, 1'b0, 8'h00, 32'hA000_0007);
        do_instr(0, 0, 1'b0, 8'h00, 32'hA000_0008);
        do_instr(0, 0, 1'b1, 8'h03, 32'hA000_0009);
        check("branch_fwd_addr", imem_addr_a, 32'h0000_0020);
        do_instr(0, 3, 1'b0, 8'h00, 32'hA000_000A);
        do_instr(1, 2, 1'b1, 8'h80, 32'hA000_000B);
        do_instr(2, 1, 1'b1, 8'h7F, 32'hA000_000C);

        for (int t = 0; t < 40; t++) begin
            do_instr(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                     1'($urandom), 8'($urandom), $urandom);
        end

        // Reset in the middle of a miss drops the request immediately.
        busywait = 1'b1;
        step();
        step();
        rst = 1'b1;
        step();
        exp_pc_a    = 32'h0;
        exp_pc_b    = RESET_PC_B;
        exp_retired = 32'd0;
        exp_stalls  = 32'd0;
        check("midmiss_read", {31'd0, imem_read_a}, 32'd0);
        check("midmiss_pc_a", pc_a, 32'h0);
        check("midmiss_pc_b", pc_b, RESET_PC_B);
        check("midmiss_valid", {31'd0, instr_valid_a}, 32'd0);
        check_counters();
        $display("reset mid-miss -> pc_a=%h pc_b=%h", pc_a, pc_b);
        rst = 1'b0;
        step();
        do_instr(0, 0, 1'b0, 8'h00, 32'hB000_0001);
        do_instr(1, 1, 1'b0, 8'h00, 32'hB000_0002);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
